// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI/QSPI frame engine.
package spi_pkg;

  localparam int unsigned MAX_TX_BYTES = 260;
  localparam int unsigned MAX_RX_BITS  = 64;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StRecv,
    StGap
  } state_e;

endpackage

// File: rtl/spi_cmd_engine.sv
// Bit-level SPI/QSPI frame engine: shifts out N command/data bytes, then
// shifts in M bytes, in x1 or x4 mode. Flash C is ~clk at the top level.
module spi_cmd_engine
  import spi_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trigger,
  input  logic                      quad,
  input  logic [8:0]                data_in_count,
  input  logic [7:0]                data_out_count,
  input  logic [MAX_TX_BYTES*8-1:0] data_in,
  output logic [MAX_RX_BITS-1:0]    data_out,
  output logic                      busy,
  inout  wire  [3:0]                DQio,
  output logic                      S
);

  state_e state_q, state_d;

  logic [MAX_TX_BYTES*8-1:0] tx_data_q;
  logic [11:0]               tx_left_q;  // bits still to send, current one included
  logic [10:0]               rx_left_q;  // bits still to capture
  logic                      quad_q;
  logic [MAX_RX_BITS-1:0]    data_out_q;

  logic [8:0]  n_bytes;
  logic [11:0] tx_step;
  logic [10:0] rx_step;
  logic        tx_last;
  logic        rx_last;
  logic [3:0]  dq_out;
  logic [3:0]  dq_oe;

  // Byte count clamp and per-cycle step sizes
  always_comb begin
    n_bytes = (data_in_count > 9'(MAX_TX_BYTES)) ? 9'(MAX_TX_BYTES) : data_in_count;
    tx_step = quad_q ? 12'd4 : 12'd1;
    rx_step = quad_q ? 11'd4 : 11'd1;
    tx_last = (tx_left_q == tx_step);
    rx_last = (rx_left_q == rx_step);
  end

  // State register; reset abandons any frame and raises S at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = (n_bytes == 9'd0) ? StGap : StSend;
        end
      end
      StSend: begin
        if (tx_last) begin
          state_d = (rx_left_q != 11'd0) ? StRecv : StGap;
        end
      end
      StRecv: begin
        if (rx_last) begin
          state_d = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state; pads driven from latched data
  always_comb begin
    busy   = (state_q != StIdle);
    S      = !((state_q == StSend) || (state_q == StRecv));
    dq_out = 4'b0000;
    dq_oe  = 4'b0000;
    if (state_q == StSend) begin
      if (quad_q) begin
        dq_out = tx_data_q[tx_left_q - 12'd4 +: 4];
        dq_oe  = 4'b1111;
      end else begin
        // W# and HOLD# held inactive, DQ1 left for the flash
        dq_out = {2'b11, 1'b0, tx_data_q[tx_left_q - 12'd1]};
        dq_oe  = 4'b1101;
      end
    end else if ((state_q == StRecv) && !quad_q) begin
      dq_out = 4'b1100;
      dq_oe  = 4'b1100;
    end
  end

  // Frame datapath: latch on trigger, count down sends, shift in receives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_q  <= '0;
      tx_left_q  <= '0;
      rx_left_q  <= '0;
      quad_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            tx_data_q  <= data_in;
            tx_left_q  <= {n_bytes, 3'b000};
            rx_left_q  <= {data_out_count, 3'b000};
            quad_q     <= quad;
            data_out_q <= '0;
          end
        end
        StSend: begin
          tx_left_q <= tx_left_q - tx_step;
        end
        StRecv: begin
          rx_left_q <= rx_left_q - rx_step;
          if (quad_q) begin
            data_out_q <= {data_out_q[MAX_RX_BITS-5:0], DQio};
          end else begin
            data_out_q <= {data_out_q[MAX_RX_BITS-2:0], DQio[1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out = data_out_q;

  assign DQio[0] = dq_oe[0] ? dq_out[0] : 1'bz;
  assign DQio[1] = dq_oe[1] ? dq_out[1] : 1'bz;
  assign DQio[2] = dq_oe[2] ? dq_out[2] : 1'bz;
  assign DQio[3] = dq_oe[3] ? dq_out[3] : 1'bz;

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Directed bench for spi_cmd_engine with a simple flash read-data model.
module tb_spi_cmd_engine;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trigger = 1'b0;
  logic          quad = 1'b0;
  logic [8:0]    data_in_count = '0;
  logic [7:0]    data_out_count = '0;
  logic [2079:0] data_in = '0;
  logic [63:0]   data_out;
  logic          busy;
  logic          S;
  wire  [3:0]    DQio;

  logic [3:0]    fl_out = '0;
  logic [3:0]    fl_oe = '0;
  logic [7:0]    rx_bytes [16];
  logic [2079:0] tx_got;
  logic [2079:0] pp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_fl
    assign DQio[i] = fl_oe[i] ? fl_out[i] : 1'bz;
  end

  spi_cmd_engine dut (
    .clk            (clk),
    .reset          (reset),
    .trigger        (trigger),
    .quad           (quad),
    .data_in_count  (data_in_count),
    .data_out_count (data_out_count),
    .data_in        (data_in),
    .data_out       (data_out),
    .busy           (busy),
    .DQio           (DQio),
    .S              (S)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one frame; flash drives read unit j just after edge T0+txc+j.
  task automatic run_frame(input string tag, input logic q, input int n_cnt, input int m,
                           input logic [2079:0] din, input logic [2079:0] exp_tx,
                           input int exp_slow, input int exp_busy,
                           input logic [63:0] exp_dout);
    int n_eff, upb, txc, rxc, c, slow, bcnt, j;
    bit done;
    logic [7:0] rb;
    n_eff = (n_cnt > 260) ? 260 : n_cnt;
    upb   = q ? 4 : 1;
    txc   = n_eff * 8 / upb;
    rxc   = (n_eff == 0) ? 0 : m * 8 / upb;
    @(negedge clk);
    quad = q;
    data_in_count = 9'(n_cnt);
    data_out_count = 8'(m);
    data_in = din;
    trigger = 1'b1;
    @(posedge clk);
    #1 trigger = 1'b0;
    slow = 0;
    bcnt = 0;
    c = 0;
    done = 0;
    tx_got = '0;
    while (!done && c < 4000) begin
      if (c >= txc && c < txc + rxc) begin
        j = c - txc;
        if (q) begin
          rb = rx_bytes[j / 2];
          fl_out = (j % 2 == 0) ? rb[7:4] : rb[3:0];
          fl_oe = 4'b1111;
        end else begin
          rb = rx_bytes[j / 8];
          fl_out = {2'b00, rb[7 - (j % 8)], 1'b0};
          fl_oe = 4'b0010;
        end
      end else begin
        fl_oe = 4'b0000;
      end
      @(negedge clk);
      if (busy) bcnt++;
      if (!S) slow++;
      if (c < txc) begin
        if (q) tx_got = {tx_got[2075:0], DQio};
        else tx_got = {tx_got[2078:0], DQio[0]};
      end
      if (q && rxc > 0 && c == txc) check_eq({tag, "_release"}, 64'(dut.dq_oe), 64'd0);
      if (!busy) done = 1;
      @(posedge clk);
      #1 c++;
    end
    fl_oe = 4'b0000;
    if (!done) check_eq({tag, "_timeout"}, 64'd1, 64'd0);
    if (txc * upb <= 64) check_eq({tag, "_tx"}, tx_got[63:0], exp_tx[63:0]);
    else check_eq({tag, "_tx_biterrs"}, 64'($countones(tx_got ^ exp_tx)), 64'd0);
    check_eq({tag, "_s_low"}, 64'(slow), 64'(exp_slow));
    check_eq({tag, "_busy"}, 64'(bcnt), 64'(exp_busy));
    check_eq({tag, "_dout"}, data_out, exp_dout);
  endtask

  initial begin
    pp_data = '0;
    pp_data[2079 -: 32] = 32'h0212_3456;
    for (int i = 0; i < 256; i++) pp_data[2047 - 8 * i -: 8] = 8'(i);

    #12;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_s", 64'(S), 64'd1);
    check_eq("rst_dout", data_out, 64'd0);
    check_eq("rst_oe", 64'(dut.dq_oe), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // x1 RDID
    rx_bytes[0] = 8'h20;
    run_frame("rdid", 1'b0, 1, 1, 2080'h9F, 2080'h9F, 16, 17, 64'h20);

    // x1 WRVECR, no read phase
    run_frame("wrvecr", 1'b0, 2, 0, 2080'h61AB, 2080'h61AB, 16, 17, 64'h0);

    // x4 MIORDID
    rx_bytes[0] = 8'h20;
    rx_bytes[1] = 8'hBA;
    rx_bytes[2] = 8'h18;
    run_frame("miordid", 1'b1, 1, 3, 2080'hAF, 2080'hAF, 8, 9, 64'h20BA18);

    // N=0: S never falls, one GAP cycle, data_out cleared
    run_frame("n0", 1'b0, 0, 3, 2080'h0, 2080'h0, 0, 1, 64'h0);

    // x1 page program, full 260 bytes
    run_frame("pp", 1'b0, 260, 0, pp_data, pp_data, 2080, 2081, 64'h0);
    check_eq("pp_first", 64'(tx_got[2079:2072]), 64'h02);
    check_eq("pp_addr", 64'(tx_got[2071:2048]), 64'h123456);
    check_eq("pp_last", 64'(tx_got[7:0]), 64'hFF);

    // Count above 260 clamps to 260 (x4)
    run_frame("clamp", 1'b1, 300, 0, pp_data, pp_data, 520, 521, 64'h0);

    // x1 read of 10 bytes keeps only the last 8
    for (int i = 0; i < 10; i++) rx_bytes[i] = 8'(i + 1);
    run_frame("read10", 1'b0, 1, 10, 2080'h03, 2080'h03, 88, 89, 64'h0304_0506_0708_090A);

    // Reset in the middle of a frame
    @(negedge clk);
    quad = 1'b0;
    data_in_count = 9'd2;
    data_out_count = 8'd2;
    data_in = 2080'h0B12;
    trigger = 1'b1;
    @(posedge clk);
    #1 trigger = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_s", 64'(S), 64'd1);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_oe", 64'(dut.dq_oe), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rx_bytes[0] = 8'h5A;
    run_frame("post_rst", 1'b0, 1, 1, 2080'h9F, 2080'h9F, 16, 17, 64'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
